icache_assoc: RTL and testbench

- Parametrised read-only instruction cache: set-associative (1 or 2 ways), configurable sets and line size, true-LRU replacement.
- Sits between the CPU fetch stage and the line-wide instruction memory; replaces the fixed 8-set direct-mapped icache.
- Adds a request strobe, a multi-cycle flush walk, and saturating hit/miss counters.

---
 rtl/icache_assoc.sv | 182 ++++++++++++++++++
 tb/tb_icache_assoc.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_assoc.sv
// Set-associative (1 or 2 way) read-only instruction cache with true-LRU replacement,
// multi-cycle flush walk and saturating hit/miss counters.
module icache_assoc #(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned WORDS_PER_LINE = 4,
   parameter int unsigned NUM_SETS       = 8,
   parameter int unsigned WAYS           = 2,
   parameter int unsigned CNT_WIDTH      = 16
) (
   input  logic                                   clock,
   input  logic                                   reset,
   input  logic                                   read,
   input  logic [ADDR_WIDTH-1:0]                  address,
   input  logic                                   flush,
   output logic [DATA_WIDTH-1:0]                  instruction,
   output logic                                   busywait,
   output logic                                   mem_read,
   output logic [ADDR_WIDTH-$clog2(DATA_WIDTH/8)-$clog2(WORDS_PER_LINE)-1:0] mem_address,
   input  logic [DATA_WIDTH*WORDS_PER_LINE-1:0]   mem_readdata,
   input  logic                                   mem_busywait,
   output logic [CNT_WIDTH-1:0]                   hit_count,
   output logic [CNT_WIDTH-1:0]                   miss_count
);

   localparam int unsigned OB = $clog2(DATA_WIDTH/8);
   localparam int unsigned WB = $clog2(WORDS_PER_LINE);
   localparam int unsigned IB = $clog2(NUM_SETS);
   localparam int unsigned MW = ADDR_WIDTH - OB - WB;
   localparam int unsigned TW = MW - IB;
   localparam int unsigned LW = DATA_WIDTH * WORDS_PER_LINE;

   typedef enum logic [1:0] {IDLE, MEM_READ, CACHE_WRITE, FLUSH} state_t;

   state_t            state, state_nxt;
   logic [TW-1:0]     tag_mem  [WAYS][NUM_SETS];
   logic [LW-1:0]     data_mem [WAYS][NUM_SETS];
   logic [NUM_SETS-1:0] valid  [WAYS];
   logic [LW-1:0]     line_buf;
   logic              mem_seen;
   logic              flush_pending;
   logic [IB-1:0]     flush_set;

   logic [TW-1:0]     req_tag;
   logic [IB-1:0]     req_idx;
   logic [WB-1:0]     req_word;
   logic [TW-1:0]     wtag;
   logic [IB-1:0]     widx;
   logic [WAYS-1:0]   hit_way;
   logic              hit_idx;
   logic [LW-1:0]     hit_line;
   logic              hit;
   logic              victim;
   logic              hit_upd, miss_upd, line_cap, fill, enter_flush;
   logic              unused_bits;

   assign req_tag     = address[ADDR_WIDTH-1 -: TW];
   assign req_idx     = address[OB+WB +: IB];
   assign req_word    = address[OB +: WB];
   assign unused_bits = ^address[OB-1:0];
   assign wtag        = mem_address[MW-1 -: TW];
   assign widx        = mem_address[IB-1:0];

   // Parallel tag compare across ways; the lowest matching way wins
   always_comb begin
      hit_way  = '0;
      hit_idx  = 1'b0;
      hit_line = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (valid[w][req_idx] && tag_mem[w][req_idx] == req_tag) begin
            hit_way[w] = 1'b1;
            hit_idx    = 1'(w);
            hit_line   = data_mem[w][req_idx];
         end
      end
   end

   assign hit         = read && (|hit_way);
   assign instruction = hit ? hit_line[req_word*DATA_WIDTH +: DATA_WIDTH] : '0;
   assign mem_read    = (state == MEM_READ);
   assign busywait    = reset && ((state == IDLE && read && !hit && !flush_pending) ||
                                  state != IDLE);

   // Next-state and per-cycle control strobes
   always_comb begin
      state_nxt = state;
      hit_upd   = 1'b0;
      miss_upd  = 1'b0;
      line_cap  = 1'b0;
      fill      = 1'b0;
      case (state)
         IDLE: begin
            hit_upd = hit && !flush;
            if (flush || flush_pending) begin
               state_nxt = FLUSH;
            end else if (read && !hit) begin
               state_nxt = MEM_READ;
               miss_upd  = 1'b1;
            end
         end
         MEM_READ: begin
            if (mem_seen && !mem_busywait) begin
               state_nxt = CACHE_WRITE;
               line_cap  = 1'b1;
            end
         end
         CACHE_WRITE: begin
            fill      = 1'b1;
            state_nxt = flush_pending ? FLUSH : IDLE;
         end
         FLUSH: begin
            if (flush_set == IB'(NUM_SETS - 1)) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign enter_flush = (state_nxt == FLUSH) && (state != FLUSH);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         flush_pending <= 1'b0;
         mem_seen      <= 1'b0;
         flush_set     <= '0;
         mem_address   <= '0;
         hit_count     <= '0;
         miss_count    <= '0;
         for (int w = 0; w < WAYS; w++) valid[w] <= '0;
      end else begin
         state         <= state_nxt;
         flush_pending <= (flush_pending && !enter_flush) || (flush && state != IDLE);
         mem_seen      <= (state == MEM_READ && !line_cap) ? (mem_seen || mem_busywait) : 1'b0;
         if (enter_flush)         flush_set <= '0;
         else if (state == FLUSH) flush_set <= flush_set + IB'(1);
         if (miss_upd) begin
            mem_address <= {req_tag, req_idx};
            if (miss_count != '1) miss_count <= miss_count + CNT_WIDTH'(1);
         end
         if (hit_upd && hit_count != '1) hit_count <= hit_count + CNT_WIDTH'(1);
         for (int w = 0; w < WAYS; w++) begin
            if (state == FLUSH)                    valid[w][flush_set] <= 1'b0;
            else if (fill && w == int'(victim))    valid[w][widx]      <= 1'b1;
         end
      end
   end

   // Line storage is not reset; valid bits gate every use
   always_ff @(posedge clock) begin
      if (line_cap) line_buf <= mem_readdata;
      for (int w = 0; w < WAYS; w++) begin
         if (fill && w == int'(victim)) begin
            tag_mem[w][widx]  <= wtag;
            data_mem[w][widx] <= line_buf;
         end
      end
   end

   generate
      if (WAYS == 2) begin : g_lru
         logic [NUM_SETS-1:0] lru;

         // LRU bit names the way to evict next
         always_ff @(posedge clock or negedge reset) begin
            if (!reset)              lru <= '0;
            else if (state == FLUSH) lru[flush_set] <= 1'b0;
            else if (fill)           lru[widx] <= ~victim;
            else if (hit_upd)        lru[req_idx] <= ~hit_idx;
         end

         always_comb begin
            victim = 1'b0;
            if (!valid[0][widx])      victim = 1'b0;
            else if (!valid[1][widx]) victim = 1'b1;
            else                      victim = lru[widx];
         end
      end else begin : g_direct
         assign victim = 1'b0;
      end
   endgenerate

endmodule

// File: tb/tb_icache_assoc.sv
// Scoreboard bench for icache_assoc: directed fetches, a fixed-latency line memory
// model, and a monitor that checks every accepted fetch against queued expectations.
module tb_icache_assoc;

   localparam int unsigned AW  = 32;
   localparam int unsigned DW  = 32;
   localparam int unsigned MAW = 28;
   localparam int unsigned LW  = 128;
   localparam int unsigned CW  = 4;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] instr;
      int          stall;
   } exp_t;

   logic           clock, reset, read, flush, busywait, mem_read, mem_busywait;
   logic [AW-1:0]  address;
   logic [DW-1:0]  instruction;
   logic [MAW-1:0] mem_address;
   logic [LW-1:0]  mem_readdata;
   logic [CW-1:0]  hit_count, miss_count;

   exp_t sb_q[$];
   int   errors = 0;
   int   checks = 0;

   icache_assoc #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WORDS_PER_LINE(4),
      .NUM_SETS(8), .WAYS(2), .CNT_WIDTH(CW)
   ) dut (
      .clock(clock), .reset(reset), .read(read), .address(address), .flush(flush),
      .instruction(instruction), .busywait(busywait), .mem_read(mem_read),
      .mem_address(mem_address), .mem_readdata(mem_readdata),
      .mem_busywait(mem_busywait), .hit_count(hit_count), .miss_count(miss_count)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   // Line L: line 4 holds {D,C,B,A}; others hold 0x1000_0000 | L<<8 | word
   function automatic logic [LW-1:0] line_of(input logic [MAW-1:0] la);
      logic [LW-1:0] l;
      for (int w = 0; w < 4; w++) begin
         if (la == 28'h4) l[w*32 +: 32] = 32'hA + 32'(w);
         else             l[w*32 +: 32] = 32'h1000_0000 | (32'(la) << 8) | 32'(w);
      end
      return l;
   endfunction

   // Memory: busy for 3 cycles after mem_read rises, then presents the line
   initial begin : memory
      int mcnt;
      mcnt         = 0;
      mem_busywait = 1'b0;
      mem_readdata = '0;
      forever begin
         @(posedge clock);
         #1;
         if (mem_read) begin
            mcnt++;
            mem_busywait = (mcnt <= 3);
            mem_readdata = line_of(mem_address);
         end else begin
            mcnt         = 0;
            mem_busywait = 1'b0;
         end
      end
   end

   // Monitor: every accepted fetch pops one expectation
   initial begin : monitor
      int   stall;
      exp_t e;
      stall = 0;
      forever begin
         @(negedge clock);
         if (!reset || !read) begin
            stall = 0;
         end else if (busywait) begin
            stall++;
         end else begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_accept: got accept at 0x%0h required none", address);
            end else begin
               e = sb_q.pop_front();
               check($sformatf("instr@%0h", e.addr), 64'(instruction), 64'(e.instr));
               check($sformatf("addr@%0h", e.addr), 64'(address), 64'(e.addr));
               if (e.stall >= 0)
                  check($sformatf("stall@%0h", e.addr), 64'(stall), 64'(e.stall));
               if (e.stall == 0)
                  check($sformatf("mem_read_on_hit@%0h", e.addr), 64'(mem_read), 64'd0);
            end
            stall = 0;
         end
      end
   end

   task automatic issue(input logic [31:0] a, input logic [31:0] ins, input int st);
      exp_t e;
      e.addr  = a;
      e.instr = ins;
      e.stall = st;
      sb_q.push_back(e);
      read    = 1'b1;
      address = a;
   endtask

   task automatic wait_accept(input string name);
      int n;
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (busywait && n < 200);
      if (busywait) begin
         checks++;
         errors++;
         $display("FAIL %s: got busywait stuck at 1 required 0", name);
      end
      @(posedge clock);
      #1;
   endtask

   task automatic do_read(input logic [31:0] a, input logic [31:0] ins, input int st);
      issue(a, ins, st);
      wait_accept($sformatf("accept@%0h", a));
   endtask

   task automatic wait_mem(input string name);
      int n;
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!mem_read && n < 50);
      check(name, 64'(mem_read), 64'd1);
   endtask

   task automatic check_counts(input string tag, input int h, input int m);
      check({tag, "_hit_count"}, 64'(hit_count), 64'(h));
      check({tag, "_miss_count"}, 64'(miss_count), 64'(m));
   endtask

   initial begin : stimulus
      int n;
      reset   = 1'b0;
      read    = 1'b0;
      flush   = 1'b0;
      address = '0;

      // Reset state
      repeat (2) @(posedge clock);
      #1;
      check("rst_instruction", 64'(instruction), 64'd0);
      check("rst_busywait", 64'(busywait), 64'd0);
      check("rst_mem_read", 64'(mem_read), 64'd0);
      check("rst_mem_address", 64'(mem_address), 64'd0);
      check_counts("rst", 0, 0);
      @(negedge clock) reset = 1'b1;
      @(posedge clock);
      #1;

      // Cold miss
      issue(32'h40, 32'hA, 6);
      wait_mem("cold_mem_read");
      check("cold_mem_address", 64'(mem_address), 64'h4);
      wait_accept("cold_accept");
      check_counts("cold", 1, 1);

      // Same-line hits
      do_read(32'h44, 32'hB, 0);
      do_read(32'h48, 32'hC, 0);
      do_read(32'h4C, 32'hD, 0);
      check_counts("hits", 4, 1);

      // LRU eviction in set 0
      do_read(32'h000, 32'h1000_0000, 6);
      do_read(32'h080, 32'h1000_0800, 6);
      do_read(32'h004, 32'h1000_0001, 0);
      do_read(32'h100, 32'h1000_1000, 6);
      do_read(32'h000, 32'h1000_0000, 0);
      do_read(32'h080, 32'h1000_0800, 6);
      check_counts("lru", 10, 5);

      // Flush in IDLE
      read  = 1'b0;
      flush = 1'b1;
      @(posedge clock);
      #1;
      flush = 1'b0;
      n = 0;
      repeat (20) begin
         @(negedge clock);
         if (busywait) n++;
      end
      check("flush_busy_cycles", 64'(n), 64'd8);
      @(posedge clock);
      #1;
      check_counts("flush", 10, 5);
      do_read(32'h40, 32'hA, 6);
      check_counts("post_flush", 11, 6);

      // Flush during refill: refill, 8-cycle flush, then the held read misses again
      issue(32'hC0, 32'h1000_0C00, 20);
      wait_mem("refill_mem_read");
      @(posedge clock);
      #1;
      flush = 1'b1;
      @(posedge clock);
      #1;
      flush = 1'b0;
      wait_accept("refill_accept");
      do_read(32'h40, 32'hA, 6);
      check_counts("refill_flush", 13, 9);

      // Reset in the middle of a refill
      read    = 1'b1;
      address = 32'h50;
      wait_mem("abort_mem_read");
      @(posedge clock);
      #3;
      reset = 1'b0;
      #1;
      check("midrst_mem_read", 64'(mem_read), 64'd0);
      check("midrst_busywait", 64'(busywait), 64'd0);
      check("midrst_mem_address", 64'(mem_address), 64'd0);
      check_counts("midrst", 0, 0);
      read = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock) reset = 1'b1;
      @(posedge clock);
      #1;
      do_read(32'h40, 32'hA, 6);
      check_counts("after_rst", 1, 1);

      // Hit counter saturation at 4 bits
      for (int i = 0; i < 20; i++)
         do_read(32'h40 + 32'(4 * (i % 4)), 32'hA + 32'(i % 4), 0);
      check_counts("saturate", 15, 1);

      read = 1'b0;
      repeat (2) @(posedge clock);
      check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
